// File: rtl/mcpu_ctrl.sv
// ============================================================================
// Module   : mcpu_ctrl
// Purpose  : Multi-cycle RV32I control FSM (fetch/decode/execute/mem/wb)
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mcpu_ctrl #(
    parameter int WAIT_MIO = 1,
    parameter int ST_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [4:0]      OPcode,
    input  logic [2:0]      Fun3,
    input  logic            Fun7,
    input  logic            Zero,
    input  logic            MIO_ready,
    output logic            PCWrite,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemRW,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      PCSource,
    output logic [2:0]      ImmSel,
    output logic [3:0]      ALU_Control,
    output logic            CPU_MIO,
    output logic            inst_done,
    output logic [ST_W-1:0] state
);

    typedef enum logic [3:0] {
        S_IF   = 4'd0,
        S_ID   = 4'd1,
        S_MA   = 4'd2,
        S_MR   = 4'd3,
        S_LWB  = 4'd4,
        S_MW   = 4'd5,
        S_EXR  = 4'd6,
        S_EXI  = 4'd7,
        S_RWB  = 4'd8,
        S_BR   = 4'd9,
        S_JAL  = 4'd10,
        S_JALR = 4'd11,
        S_LUI  = 4'd12
    } state_t;

    state_t state_q, state_d;
    logic   rdy;

    assign rdy   = MIO_ready | (WAIT_MIO == 0);
    assign state = ST_W'(state_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IF;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        PCWrite     = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemRW       = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        MemtoReg    = 2'b00;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        ImmSel      = 3'b000;
        ALU_Control = 4'b0010;
        CPU_MIO     = 1'b0;
        inst_done   = 1'b0;

        case (state_q)
            S_IF: begin
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                ALUSrcB = 2'b01;
                if (rdy) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                // OldPC + imm is precomputed here so branches/JAL can use ALUOut
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b10;
                case (OPcode)
                    5'b11000: ImmSel = 3'b010;
                    5'b11011: ImmSel = 3'b011;
                    5'b00101: ImmSel = 3'b100;
                    5'b01000: ImmSel = 3'b001;
                    default:  ImmSel = 3'b000;
                endcase
                case (OPcode)
                    5'b01100: state_d = S_EXR;
                    5'b00100: state_d = S_EXI;
                    5'b00000,
                    5'b01000: state_d = S_MA;
                    5'b11000: state_d = S_BR;
                    5'b11011: state_d = S_JAL;
                    5'b11001: state_d = S_JALR;
                    5'b01101: state_d = S_LUI;
                    5'b00101: state_d = S_RWB;
                    default: begin
                        inst_done = 1'b1;
                        state_d   = S_IF;
                    end
                endcase
            end
            S_MA: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                ImmSel  = (OPcode == 5'b01000) ? 3'b001 : 3'b000;
                state_d = (OPcode == 5'b01000) ? S_MW : S_MR;
            end
            S_MR: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
                CPU_MIO = 1'b1;
                if (rdy) state_d = S_LWB;
            end
            S_LWB: begin
                RegWrite  = 1'b1;
                MemtoReg  = 2'b01;
                inst_done = 1'b1;
                state_d   = S_IF;
            end
            S_MW: begin
                IorD    = 1'b1;
                MemRW   = 1'b1;
                CPU_MIO = 1'b1;
                if (rdy) begin
                    inst_done = 1'b1;
                    state_d   = S_IF;
                end
            end
            S_EXR: begin
                ALUSrcA = 2'b01;
                state_d = S_RWB;
                case ({Fun3, Fun7})
                    4'b0000: ALU_Control = 4'b0010;
                    4'b0001: ALU_Control = 4'b0110;
                    4'b0010: ALU_Control = 4'b0100;
                    4'b0100: ALU_Control = 4'b0111;
                    4'b0110: ALU_Control = 4'b1000;
                    4'b1000: ALU_Control = 4'b0011;
                    4'b1010: ALU_Control = 4'b0101;
                    4'b1011: ALU_Control = 4'b1101;
                    4'b1100: ALU_Control = 4'b0001;
                    4'b1110: ALU_Control = 4'b0000;
                    default: ALU_Control = 4'b0010;
                endcase
            end
            S_EXI: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = S_RWB;
                case (Fun3)
                    3'b000: ALU_Control = 4'b0010;
                    3'b010: ALU_Control = 4'b0111;
                    3'b011: ALU_Control = 4'b1000;
                    3'b100: ALU_Control = 4'b0011;
                    3'b110: ALU_Control = 4'b0001;
                    3'b111: ALU_Control = 4'b0000;
                    3'b001: ALU_Control = 4'b0100;
                    default: ALU_Control = Fun7 ? 4'b1101 : 4'b0101;
                endcase
            end
            S_LUI: begin
                ALUSrcA = 2'b11;
                ALUSrcB = 2'b10;
                ImmSel  = 3'b100;
                state_d = S_RWB;
            end
            S_RWB: begin
                RegWrite  = 1'b1;
                inst_done = 1'b1;
                state_d   = S_IF;
            end
            S_BR: begin
                ALUSrcA     = 2'b01;
                ALU_Control = 4'b0110;
                PCSource    = 2'b01;
                inst_done   = 1'b1;
                state_d     = S_IF;
                case (Fun3)
                    3'b000:  PCWrite = Zero;
                    3'b001:  PCWrite = ~Zero;
                    default: PCWrite = 1'b0;
                endcase
            end
            S_JAL: begin
                PCWrite   = 1'b1;
                PCSource  = 2'b01;
                RegWrite  = 1'b1;
                MemtoReg  = 2'b10;
                inst_done = 1'b1;
                state_d   = S_IF;
            end
            S_JALR: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                PCSource  = 2'b10;
                PCWrite   = 1'b1;
                RegWrite  = 1'b1;
                MemtoReg  = 2'b10;
                inst_done = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

endmodule

`default_nettype wire
